// File: rtl/sync_fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO.
// Holds data width, default depth, pointer width and the data type.
package sync_fifo_pkg;
  localparam int DATA_W    = 8;
  localparam int DEPTH_DEF = 16;
  localparam int PTR_W     = $clog2(DEPTH_DEF);
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// Register array with one write port and one registered read port.
// Ports: clk, rstn, we_i/waddr_i/wdata_i, re_i/raddr_i, rdata_o.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DW    = sync_fifo_pkg::DATA_W,
  parameter int DEPTH = sync_fifo_pkg::DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage carries no reset; only the read register does.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, flag decode.
// Ports: clk, rstn, i_wren/i_wrdata, i_rden, o_rddata, status flags.
// Option SYNC_FIFO_ERR_EN adds sticky o_ovf / o_udf.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W       = sync_fifo_pkg::DATA_W,
  parameter int DEPTH        = sync_fifo_pkg::DEPTH_DEF,
  parameter int ALM_EMPTY_TH = 2,
  parameter int ALM_FULL_TH  = DEPTH - 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_empty,
  output logic              o_alm_empty,
  output logic              o_alm_full,
  output logic              o_full
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic              o_ovf,
  output logic              o_udf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_acc;
  logic          rd_acc;

  // Flags come from the count register only.
  assign o_empty     = (cnt_q == '0);
  assign o_full      = (cnt_q == CW'(DEPTH));
  assign o_alm_empty = (cnt_q <= CW'(ALM_EMPTY_TH));
  assign o_alm_full  = (cnt_q >= CW'(ALM_FULL_TH));

  assign wr_acc = i_wren && !o_full;
  assign rd_acc = i_rden && !o_empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_acc) wptr_d = wptr_q + AW'(1);
    if (rd_acc) rptr_d = rptr_q + AW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  sync_fifo_mem #(
    .DW    (DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (i_wrdata),
    .re_i    (rd_acc),
    .raddr_i (rptr_q),
    .rdata_o (o_rddata)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q || (i_wren && o_full);
    udf_d = udf_q || (i_rden && o_empty);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign o_ovf = ovf_q;
  assign o_udf = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (DEPTH 16, DATA_W 8).
// Stimulus pushes expected post-edge state; monitor pops and compares.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic  clk = 1'b0;
  logic  rstn = 1'b0;
  logic  i_wren = 1'b0;
  logic  i_rden = 1'b0;
  data_t i_wrdata = '0;
  data_t o_rddata;
  logic  o_empty, o_alm_empty, o_alm_full, o_full;
`ifdef SYNC_FIFO_ERR_EN
  logic  o_ovf, o_udf;
`endif

  sync_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_wren      (i_wren),
    .i_wrdata    (i_wrdata),
    .i_rden      (i_rden),
    .o_rddata    (o_rddata),
    .o_empty     (o_empty),
    .o_alm_empty (o_alm_empty),
    .o_alm_full  (o_alm_full),
    .o_full      (o_full)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .o_ovf       (o_ovf),
    .o_udf       (o_udf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    data_t      rd;
    logic [3:0] flg;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t  sb[$];
  data_t mq[$];
  data_t last_rd = '0;
  logic  m_ovf = 1'b0;
  logic  m_udf = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mflags(input int n);
    mflags = {n == 0, n <= 2, n >= DEPTH - 2, n == DEPTH};
  endfunction

  // Reference queue model; expected state after the coming edge.
  task automatic step(input logic wr,
                      input data_t wd,
                      input logic rd);
    exp_t e;
    logic f, em;
    @(negedge clk);
    i_wren   = wr;
    i_wrdata = wd;
    i_rden   = rd;
    f  = (mq.size() == DEPTH);
    em = (mq.size() == 0);
    if (wr && f) m_ovf = 1'b1;
    if (rd && em) m_udf = 1'b1;
    if (rd && !em) last_rd = mq.pop_front();
    if (wr && !f) mq.push_back(wd);
    e.rd  = last_rd;
    e.flg = mflags(mq.size());
    e.ovf = m_ovf;
    e.udf = m_udf;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rddata", 32'(o_rddata), 32'(e.rd));
      chk("flags", 32'({o_empty, o_alm_empty,
                        o_alm_full, o_full}),
          32'(e.flg));
`ifdef SYNC_FIFO_ERR_EN
      chk("ovf", 32'(o_ovf), 32'(e.ovf));
      chk("udf", 32'(o_udf), 32'(e.udf));
`endif
    end
  end

  task automatic chk_reset_state(input string nm);
    chk({nm, "_rddata"}, 32'(o_rddata), 32'h0);
    chk({nm, "_flags"},
        32'({o_empty, o_alm_empty, o_alm_full, o_full}),
        32'b1100);
`ifdef SYNC_FIFO_ERR_EN
    chk({nm, "_err"}, 32'({o_ovf, o_udf}), 32'b00);
`endif
  endtask

  initial begin
    #2;
    chk_reset_state("reset");
    #10 rstn = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Fill, then an overflowing write of 0xAA.
    for (int i = 0; i < DEPTH; i++) step(1'b1, data_t'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    @(posedge clk); #2;
    chk("full_hand", 32'({o_alm_full, o_full}), 32'b11);

    // Drain plus one underflowing read.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    @(posedge clk); #2;
    chk("drain_hold", 32'(o_rddata), 32'h0F);

    // Wrap-around at a steady count of 8.
    for (int i = 0; i < 8; i++) step(1'b1, data_t'(8'h20 + i), 1'b0);
    for (int i = 0; i < 40; i++)
      step(1'b1, data_t'(8'h28 + i), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    @(posedge clk); #2;
    chk("wrap_last", 32'(o_rddata), 32'h4F);

    // Simultaneous read and write while empty.
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    @(posedge clk); #2;
    chk("rw_empty", 32'(o_rddata), 32'h5A);

    // Reset in the middle of operation.
    for (int i = 0; i < 5; i++) step(1'b1, data_t'(8'h70 + i), 1'b0);
    @(negedge clk);
    i_wren = 1'b0;
    i_rden = 1'b0;
    #1 rstn = 1'b0;
    #1 chk_reset_state("midrst");
    mq.delete();
    last_rd = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    #1 rstn = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    repeat (4) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
